uart_rx_frontend: RTL and testbench
===================================

# uart_rx_frontend

Receive front-end that sits between the `rx` pad and the UART register/AXI block. It synchronises the asynchronous line, recovers 8N1 frames using a programmable bit period in clock cycles, votes each bit with a 3-sample majority, and buffers received bytes in a small FIFO. The FIFO is presented to the downstream register block as a valid/ready byte stream with framing and overrun flags and RTS flow control.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `DIV_W`, 16: width of the bit-period divisor.
- `DIV_MIN`, 8: smallest effective divisor; smaller programmed values are clamped to this.

Ports:
- `clk` input 1: single clock; all logic is on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `rx` input 1: asynchronous serial line, idle high.
- `divisor` input DIV_W: clock cycles per bit, e.g. 2604; written by the register block.
- `data` output 8: FIFO head byte.
- `valid` output 1: FIFO is non-empty.
- `ready` input 1: consumer pops the head when `valid && ready`.
- `frame_err` output 1: one-cycle pulse on a bad stop bit.
- `overrun` output 1: one-cycle pulse when a good byte is dropped because the FIFO is full.
- `rts_n` output 1: 1 (stop sending) when occupancy ≥ DEPTH-1, 0 otherwise.

## Operation
- Synchroniser: two flops, both reset to 1, giving `rx_s`. A 3-bit history `hist` holds the last three `rx_s` values and resets to 3'b111.
- Divisor latching: `div_q = max(divisor, DIV_MIN)` is latched on start detection. Writes made mid-frame therefore take effect from the next frame. `half = div_q >> 1`.
- `bcnt` is DIV_W bits, resets to 0, and counts 0..div_q-1. At div_q-1 it wraps to 0 and the bit index advances.
- `vote` is the majority of `hist`. It is evaluated when `bcnt == half+1`, so it covers the samples taken at half-1, half and half+1.
- IDLE: when `rx_s == 0`, latch `div_q`, clear `bcnt`, and go to START.
- START: at the vote point, vote = 1 is a false start and returns to IDLE with nothing recorded. Vote = 0 continues. At the wrap, go to DATA with `bidx = 0`.
- DATA: at each vote point, shift `vote` in LSB-first. At the wrap with `bidx == 7`, go to STOP; otherwise increment `bidx`.
- STOP: at the vote point the frame ends; the block does not wait for the end of the stop bit.
  - vote = 1, FIFO not full (or popped this cycle): push the byte, then go to IDLE.
  - vote = 1, FIFO full and not popped this cycle: pulse `overrun`, drop the byte, go to IDLE.
  - vote = 0: pulse `frame_err`, drop the byte, go to BRK, which waits for `rx_s == 1` before returning to IDLE. A break (line held low) therefore yields exactly one `frame_err`.
- FIFO behaviour:
  - First-word fall-through: `data` is valid whenever `valid` is high.
  - A pop and push in the same cycle when full is legal: occupancy stays at DEPTH and there is no overrun.
  - Pointers are log2(DEPTH)+1 bits and wrap naturally.
  - `data` is don't-care while `valid` is 0.
- Reset values: `valid` 0, `data` 0, `frame_err` 0, `overrun` 0, `rts_n` 0. FSM goes to IDLE and the FIFO is emptied.
- Reset mid-frame: the partial byte is discarded with no flag pulses. After reset the block resynchronises only after `rx_s` has been seen high and then falls again. A start is never detected while `hist != 3'b111` immediately after reset.

## Timing
- `rx` to `rx_s`: 2 cycles. Start detect registers the state change 1 cycle later.
- Push: in the cycle after the STOP vote point. `valid` rises in the cycle after the push.
- Total latency, from the `rx` rising edge at the start of the stop bit to `valid`: approximately half + 5 cycles.
- `frame_err` and `overrun` are asserted in the same cycle as the would-be push.
- `rts_n` is combinational from occupancy through a register, so it updates 1 cycle after a push or pop.
- Tolerance: with the clamp in force, a baud mismatch of ±4% still produces correct bytes.

## Structure
- `uart_pkg`: `rx_state_t` enum {IDLE, START, DATA, STOP, BRK}, `DIV_MIN_DEFAULT`, `UART_DATA_W = 8`. The enum and constants are shared with the TX side.
- One sub-module, `uart_rx_fifo`: parameterised on DEPTH and width, with push/pop, full/empty and count. The FSM, counters and synchroniser live in `uart_rx_frontend`.

## Test plan
- Divisor 2604: send 0xA5 as 8N1 at exactly 2604 cycles/bit with `ready = 1` → a single `valid` pulse with `data = 0xA5`, and no flags.
- Glitch: `rx` low for 500 cycles, then high → returns to IDLE, no `valid`, no flags. A following 0x3C is received correctly.
- Framing: send 0x55 with the stop bit forced to 0, then hold the line low for 5 bit times → exactly one `frame_err` pulse, FIFO unchanged, and recovery on the next valid frame.
- Overrun and RTS: `ready = 0`, send 0x01..0x05 with DEPTH = 4.
  - `rts_n` rises after the 3rd byte.
  - The 5th byte pulses `overrun`.
  - Draining yields 0x01..0x04 in order.
- Divisor change and clamp:
  - Write divisor 1302 mid-frame → the current frame completes at 2604 and the next at 1302.
  - Divisor 3 → the clamped bit period of 8 decodes 0xF0.
- Reset mid-DATA: assert `rst_n` low for 2 cycles during bit 4 → outputs return to reset values, no flags, and the next frame, 0x81, is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// UART definitions shared by the RX and TX sides: receiver state encoding and common constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } rx_state_t;

  localparam int DIV_MIN_DEFAULT = 8;
  localparam int UART_DATA_W     = 8;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through byte FIFO. Data is visible one cycle after the push.
// A push is accepted when not full, or when full and a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [W-1:0]               wdata_i,
  input  logic                       pop_i,
  output logic [W-1:0]               rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW:0]   wptr_q, rptr_q;
  logic          push_ok, pop_ok;

  assign count_o = wptr_q - rptr_q;
  assign full_o  = (count_o == (AW+1)'(DEPTH));
  assign empty_o = (wptr_q == rptr_q);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_i);
  // Head is forced to zero while empty so the output has a defined reset value.
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + (AW+1)'(1);
      if (pop_ok)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_frontend.sv
// 8N1 receiver: synchroniser, 3-sample majority voting, byte FIFO with valid/ready and RTS.
// Byte reaches valid ~half+5 cycles after the stop bit begins; a full FIFO drops it with an overrun pulse.
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int DIV_W   = 16,
  parameter int DIV_MIN = DIV_MIN_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx,
  input  logic [DIV_W-1:0] divisor,
  output logic [7:0]       data,
  output logic             valid,
  input  logic             ready,
  output logic             frame_err,
  output logic             overrun,
  output logic             rts_n
);

  localparam int AW = $clog2(DEPTH);

  rx_state_t               state_q;
  logic [1:0]              sync_q, live_q;
  logic [2:0]              hist_q;
  logic                    armed_q;
  logic [DIV_W-1:0]        div_q, bcnt_q;
  logic [2:0]              bidx_q;
  logic [UART_DATA_W-1:0]  shift_q;
  logic                    push_q, frame_err_q, overrun_q;

  logic                    rx_s, vote, vote_pt, wrap, pop;
  logic                    fifo_full, fifo_empty;
  logic [AW:0]             fifo_count;
  logic [DIV_W-1:0]        div_d;

  assign rx_s    = sync_q[1];
  assign vote    = (hist_q[0] & hist_q[1]) | (hist_q[1] & hist_q[2]) | (hist_q[0] & hist_q[2]);
  assign div_d   = (divisor < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : divisor;
  assign vote_pt = (bcnt_q == (div_q >> 1) + DIV_W'(1));
  assign wrap    = (bcnt_q == div_q - DIV_W'(1));
  assign pop     = valid && ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sync_q      <= 2'b11;
      live_q      <= 2'b00;
      hist_q      <= 3'b111;
      armed_q     <= 1'b0;
      div_q       <= DIV_W'(DIV_MIN);
      bcnt_q      <= '0;
      bidx_q      <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], rx};
      live_q      <= {live_q[0], 1'b1};
      hist_q      <= {hist_q[1:0], rx_s};
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      // rx_s only reflects the pad once the reset value has flushed out of the synchroniser.
      if (live_q[1] && rx_s) armed_q <= 1'b1;
      if (state_q == START || state_q == DATA || state_q == STOP)
        bcnt_q <= wrap ? '0 : bcnt_q + DIV_W'(1);
      case (state_q)
        IDLE: begin
          if (armed_q && !rx_s && hist_q == 3'b111) begin
            div_q   <= div_d;
            bcnt_q  <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (vote_pt && vote) begin
            state_q <= IDLE;
          end else if (wrap) begin
            bidx_q  <= '0;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (vote_pt) shift_q <= {vote, shift_q[7:1]};
          if (wrap) begin
            if (bidx_q == 3'd7) state_q <= STOP;
            else                bidx_q  <= bidx_q + 3'd1;
          end
        end
        STOP: begin
          if (vote_pt) begin
            if (!vote) begin
              frame_err_q <= 1'b1;
              state_q     <= BRK;
            end else begin
              if (!fifo_full || pop) push_q    <= 1'b1;
              else                   overrun_q <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        BRK: begin
          if (rx_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .W     (UART_DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_q),
    .wdata_i (shift_q),
    .pop_i   (pop),
    .rdata_o (data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign valid     = !fifo_empty;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign rts_n     = (fifo_count >= (AW+1)'(DEPTH - 1));

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Bench for uart_rx_frontend: drives 8N1 frames and compares against a queue-based model of delivered bytes and flags.
module tb_uart_rx_frontend;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        ready = 1'b1;
  logic [15:0] divisor = 16'd16;
  logic [7:0]  data;
  logic        valid, frame_err, overrun, rts_n;

  uart_rx_frontend #(.DEPTH(DEPTH), .DIV_W(16), .DIV_MIN(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .divisor   (divisor),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .rts_n     (rts_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int fe_cnt = 0, ov_cnt = 0, exp_fe = 0, exp_ov = 0, occ = 0;
  int errors = 0, checks = 0;
  int stop_cyc = 0, lat_cyc = 0;
  bit lat_seen = 1'b1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid && ready) got_q.push_back(data);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (valid && !lat_seen) begin
        lat_cyc  = cyc;
        lat_seen = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int per, input logic stop);
    rx = 1'b0;
    tick(per);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(per);
    end
    rx = stop;
    stop_cyc = cyc;
    tick(per);
    rx = 1'b1;
  endtask

  // Reference: a good frame is delivered, buffered, or dropped as an overrun.
  task automatic model_good(input logic [7:0] b);
    if (ready) exp_q.push_back(b);
    else if (occ < DEPTH) begin
      occ++;
      exp_q.push_back(b);
    end else exp_ov++;
  endtask

  task automatic send_good(input logic [7:0] b, input int per);
    send_frame(b, per, 1'b1);
    model_good(b);
    tick(2 * per + 10);
  endtask

  task automatic check_stream(input string tag);
    int n;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_byte"}, got_q[i], exp_q[i]);
    chk({tag, "_frame_err"}, fe_cnt, exp_fe);
    chk({tag, "_overrun"}, ov_cnt, exp_ov);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int d, eff, per;
    logic [7:0] b;

    tick(3);
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_rts_n", rts_n, 0);
    rst_n = 1'b1;
    tick(10);

    // 2604 cycles/bit; a mid-frame divisor write must not disturb this frame.
    divisor = 16'd2604;
    lat_seen = 1'b0;
    fork
      send_frame(8'hA5, 2604, 1'b1);
      begin
        tick(3 * 2604);
        divisor = 16'd1302;
      end
    join
    model_good(8'hA5);
    tick(3000);
    chk("a5_latency_window", ((lat_cyc - stop_cyc) >= 1302 + 4) && ((lat_cyc - stop_cyc) <= 1302 + 8), 1);
    check_stream("a5");
    send_good(8'h5C, 1302);
    check_stream("div1302");

    divisor = 16'd2604;
    rx = 1'b0;
    tick(500);
    rx = 1'b1;
    tick(3000);
    check_stream("glitch");
    divisor = 16'd40;
    send_good(8'h3C, 40);
    check_stream("after_glitch");

    divisor = 16'd32;
    send_frame(8'h55, 32, 1'b0);
    rx = 1'b0;
    tick(5 * 32);
    rx = 1'b1;
    exp_fe++;
    tick(64);
    check_stream("break");
    send_good(8'h66, 32);
    check_stream("after_break");

    divisor = 16'd3;
    send_good(8'hF0, 8);
    check_stream("clamp");

    divisor = 16'd100;
    send_good(8'h9B, 104);
    send_good(8'h4E, 96);
    check_stream("tolerance");

    for (int k = 0; k < 8; k++) begin
      d = $urandom_range(3, 48);
      eff = (d < 8) ? 8 : d;
      b = 8'($urandom_range(0, 255));
      divisor = 16'(d);
      send_good(b, eff);
    end
    check_stream("random");

    divisor = 16'd16;
    ready = 1'b0;
    occ = 0;
    for (int k = 1; k <= 5; k++) begin
      send_good(8'(k), 16);
      chk("rts_n_fill", rts_n, (occ >= DEPTH - 1) ? 1 : 0);
    end
    chk("overrun_seen", ov_cnt, exp_ov);
    ready = 1'b1;
    occ = 0;
    tick(20);
    check_stream("drain");
    chk("rts_n_drained", rts_n, 0);

    // Reset during bit 4 of a frame whose remaining bits are all high, with one byte buffered.
    ready = 1'b0;
    send_good(8'h5A, 16);
    rx = 1'b0;
    tick(16);
    for (int i = 0; i < 4; i++) tick(16);
    rx = 1'b1;
    tick(8);
    rst_n = 1'b0;
    tick(2);
    chk("midrst_valid", valid, 0);
    chk("midrst_data", data, 0);
    chk("midrst_flags", {frame_err, overrun}, 0);
    chk("midrst_rts_n", rts_n, 0);
    rst_n = 1'b1;
    while (occ > 0) begin
      void'(exp_q.pop_back());
      occ--;
    end
    tick(16 * 7);
    ready = 1'b1;
    tick(10);
    check_stream("midrst");
    send_good(8'h81, 16);
    check_stream("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
